// File: rtl/opram_arbiter_pkg.sv
// Shared types and defaults for the opram arbiter slice.
//   state_e                       arbiter FSM encoding (S_RUN, S_CLEAR)
//   DEFAULT_ADDR_W/DATA_W         default opram geometry
//   DEFAULT_CLEAR_VALUE           default word written by the clear sequence
package opram_arb_pkg;

    localparam int unsigned DEFAULT_ADDR_W      = 3;
    localparam int unsigned DEFAULT_DATA_W      = 8;
    localparam logic [7:0]  DEFAULT_CLEAR_VALUE = 8'h00;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/opram_arbiter_if.sv
// Requester-side bundle of the opram arbiter: loader write port, core fetch
// read port and the clear sequencer controls.
//   master : loader/core side (drives requests, addresses, data, clr_start)
//   slave  : arbiter side (drives grants, read return, clear status)
// With OPRAM_ARB_WPROT_EN defined the bundle also carries wprot / wr_err.
interface opram_arbiter_if
    import opram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

`ifdef OPRAM_ARB_WPROT_EN
    logic              wprot;
    logic              wr_err;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start, wprot,
        input  wr_gnt, rd_gnt, rd_data, rd_valid, clr_busy, clr_done, wr_err
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start, wprot,
        output wr_gnt, rd_gnt, rd_data, rd_valid, clr_busy, clr_done, wr_err
    );
`else
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start,
        input  wr_gnt, rd_gnt, rd_data, rd_valid, clr_busy, clr_done
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start,
        output wr_gnt, rd_gnt, rd_data, rd_valid, clr_busy, clr_done
    );
`endif

endinterface

// File: rtl/opram_arbiter_rd_pipe.sv
// Read-return pipe: tracks granted reads through the opram latency and
// captures mem_dout into a held rd_data register.
//   clk, rst   clock, async active-low reset
//   rd_fire    read granted this cycle
//   mem_dout   opram data out
//   rd_valid   one-cycle pulse, rd_data just captured
//   rd_data    last captured read word
// A read granted in the cycle ending at edge E has mem_dout valid after edge
// E+READ_LAT-1; it is captured on edge E+READ_LAT. READ_LAT is 1 or 2.
module opram_rd_pipe #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_fire,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [READ_LAT-1:0] pend;

    // Pending-read shift register, one stage per cycle of opram latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend[0] <= rd_fire;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                pend[i] <= pend[i-1];
            end
        end
    end

    // Capture the word while its tap is live; hold it until the next return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pend[READ_LAT-1];
            if (pend[READ_LAT-1]) begin
                rd_data <= mem_dout;
            end
        end
    end

endmodule

// File: rtl/opram_arbiter.sv
// Shares the single-port opram between the loader write port and the core
// fetch read port, and runs a clear sequence that fills every word with
// CLEAR_VALUE. Drives all opram control pins.
//   clk, rst          clock, async active-low reset
//   bus (slave)       wr_*/rd_*/clr_* requester bundle (see opram_arbiter_if)
//   mem_ce/wre/oce    opram enables
//   mem_reset         opram reset, active-high (= !rst)
//   mem_ad/din/dout   opram address, write data, read data
// Grants and mem_* pins are combinational from requests and state.
// Contended cycles alternate between the two ports via last_wr.
// Optional build macro OPRAM_ARB_WPROT_EN adds write protection: protected
// writes are granted and flagged on wr_err but never reach the opram.
module opram_arbiter
    import opram_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned       DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned       READ_LAT    = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(DEFAULT_CLEAR_VALUE)
) (
    input  logic              clk,
    input  logic              rst,
    opram_arbiter_if.slave    bus,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic              mem_oce,
    output logic              mem_reset,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned DEPTH    = 32'd1 << ADDR_W;
    localparam logic [0:0]  ST_RUN   = 1'(S_RUN);
    localparam logic [0:0]  ST_CLEAR = 1'(S_CLEAR);

    logic [0:0]        state;
    logic [0:0]        state_d;
    logic              last_wr;
    logic [ADDR_W-1:0] cnt;
    logic              clr_busy_q;
    logic              clr_done_q;

    logic              wr_gnt_c;
    logic              rd_gnt_c;
    logic              clr_beat_c;
    logic              clr_last_c;
    logic              wr_block_c;
    logic              wr_commit_c;

    // Next state and grants; grants are forced low while rst is asserted.
    always_comb begin
        state_d    = state;
        wr_gnt_c   = 1'b0;
        rd_gnt_c   = 1'b0;
        clr_beat_c = 1'b0;
        clr_last_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.wr_req && bus.rd_req) begin
                    wr_gnt_c = !last_wr;
                    rd_gnt_c = last_wr;
                end else begin
                    wr_gnt_c = bus.wr_req;
                    rd_gnt_c = bus.rd_req;
                end
                if (bus.clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_beat_c = 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    clr_last_c = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (!rst) begin
            wr_gnt_c   = 1'b0;
            rd_gnt_c   = 1'b0;
            clr_beat_c = 1'b0;
            clr_last_c = 1'b0;
        end
    end

`ifdef OPRAM_ARB_WPROT_EN
    // A protected write completes its handshake but is dropped here.
    assign wr_block_c = bus.wprot;
    assign bus.wr_err = wr_gnt_c & bus.wprot;
`else
    assign wr_block_c = 1'b0;
`endif

    assign wr_commit_c = wr_gnt_c & !wr_block_c;

    // State, arbitration history, clear counter and clear status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            last_wr    <= 1'b0;
            cnt        <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state <= state_d;
            if (bus.wr_req && bus.rd_req && (wr_gnt_c || rd_gnt_c)) begin
                last_wr <= wr_gnt_c;
            end
            if (clr_last_c) begin
                cnt <= '0;
            end else if (clr_beat_c) begin
                cnt <= ADDR_W'(cnt + 1'b1);
            end
            clr_busy_q <= (state_d == ST_CLEAR);
            clr_done_q <= clr_last_c;
        end
    end

    // Memory address/data/write-enable mux; clear beats have priority.
    always_comb begin
        mem_ad  = '0;
        mem_din = '0;
        mem_wre = 1'b0;
        if (clr_beat_c) begin
            mem_ad  = cnt;
            mem_din = CLEAR_VALUE;
            mem_wre = 1'b1;
        end else if (wr_gnt_c) begin
            mem_ad  = bus.wr_addr;
            mem_din = bus.wr_data;
            mem_wre = wr_commit_c;
        end else if (rd_gnt_c) begin
            mem_ad  = bus.rd_addr;
        end
    end

    assign mem_ce    = wr_commit_c | rd_gnt_c | clr_busy_q;
    assign mem_oce   = 1'b1;
    assign mem_reset = !rst;

    assign bus.wr_gnt   = wr_gnt_c;
    assign bus.rd_gnt   = rd_gnt_c;
    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;

    opram_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd_fire  (rd_gnt_c),
        .mem_dout (mem_dout),
        .rd_valid (bus.rd_valid),
        .rd_data  (bus.rd_data)
    );

endmodule
